// File: rtl/go_arbiter.sv
// Round-robin arbiter that hands a shared 4-phase go-sequencer to one of four requesters.
// It issues a one-cycle go, waits for the sequencer to start and then finish, and times out a stuck start.
module go_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] seq_state,
  output logic       go,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       err,
  output logic       busy
);

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StRun,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic [3:0] cnt_q, cnt_d;
  logic       go_q, go_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic [1:0] sel;
  logic       found;

  // First active request at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    grant_d = grant_q;
    done_d  = 4'b0000;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = sel;
          grant_d = 4'b0001 << sel;
          go_d    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 4'd0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (seq_state == 2'd1) begin
          state_d = StRun;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = 1'b1;
          grant_d = 4'b0000;
          ptr_d   = win_q + 2'd1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (seq_state == 2'd3) begin
          done_d  = grant_q;
          state_d = StDone;
        end
      end
      StDone: begin
        grant_d = 4'b0000;
        ptr_d   = win_q + 2'd1;
        state_d = StIdle;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 4'd0;
      go_q    <= 1'b0;
      grant_q <= 4'b0000;
      done_q  <= 4'b0000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign go    = go_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_go_arbiter.sv
// Scoreboard bench for go_arbiter: directed scenarios push expected go/done/err events,
// a negedge monitor pops and compares them with a small sequencer model attached.
module tb_go_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] seq_state;
  logic       go;
  logic [3:0] grant;
  logic [3:0] done;
  logic       err;
  logic       busy;

  logic       stall;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic       go;
    logic       err;
    logic       busy;
    logic [3:0] grant;
    logic [3:0] done;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  go_arbiter #(.TIMEOUT(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .seq_state(seq_state),
    .go       (go),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Sequencer model: 0 -> 1 on go, then 1 -> 2 -> 3 -> 0; stall pins it at 0.
  always @(posedge clock or negedge reset) begin
    if (!reset) seq_state <= 2'd0;
    else if (stall) seq_state <= 2'd0;
    else begin
      case (seq_state)
        2'd0: if (go) seq_state <= 2'd1;
        2'd1: seq_state <= 2'd2;
        2'd2: seq_state <= 2'd3;
        default: seq_state <= 2'd0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_ev(input logic g, input logic e, input logic b, input logic [3:0] gr,
                         input logic [3:0] dn, input int c);
    ev_t ev;
    ev.go = g; ev.err = e; ev.busy = b; ev.grant = gr; ev.done = dn; ev.cyc = c;
    exp_q.push_back(ev);
  endtask

  // Monitor: compares every go/done/err event against the scoreboard head.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
      chk("done_in_grant", 32'(|(done & ~grant)), 32'd0);
      if (go || err || (done != 4'b0000)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got go=%0b err=%0b grant=%b done=%b want none (cycle %0d)",
                   go, err, grant, done, cyc);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(ev.cyc));
          chk("event_fields", {21'd0, go, err, busy, grant, done},
              {21'd0, ev.go, ev.err, ev.busy, ev.grant, ev.done});
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev_t ev;
        ev = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_event: got nothing want go=%0b err=%0b grant=%b done=%b at cycle %0d",
                 ev.go, ev.err, ev.grant, ev.done, ev.cyc);
      end
    end
  end

  task automatic check_idle(input string name);
    chk({name, "_grant"}, 32'(grant), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One full nominal sequence for request pattern r, expecting winner w.
  task automatic single(input logic [3:0] r, input logic [3:0] w);
    int n;
    n = cyc + 1;
    req = r;
    push_ev(1'b1, 1'b0, 1'b1, w, 4'b0000, n);
    push_ev(1'b0, 1'b0, 1'b1, w, w, n + 4);
    repeat (5) @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    check_idle("single_idle");
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req   = 4'b0000;
    stall = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {21'd0, go, grant, done, err, busy}, 32'd0);

    // Release and request on the same cycle: first edge already arbitrates.
    reset = 1'b1;
    single(4'b0001, 4'b0001);

    // Round-robin with all requesters held, pointer freshly reset.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n = cyc + 1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_ev(1'b1, 1'b0, 1'b1, 4'b0001 << (k % 4), 4'b0000, n + 6 * k);
      push_ev(1'b0, 1'b0, 1'b1, 4'b0001 << (k % 4), 4'b0001 << (k % 4), n + 6 * k + 4);
    end
    repeat (29) @(negedge clock);
    req = 4'b0000;
    repeat (2) @(negedge clock);
    check_idle("rr_idle");

    // Pointer wrap: serve requester 2, then 0011 must go to requester 0, then 1.
    single(4'b0100, 4'b0100);
    single(4'b0011, 4'b0001);
    single(4'b0011, 4'b0010);

    // Start timeout: sequencer stuck at 0, err after TIMEOUT+2 edges, then regrant.
    stall = 1'b1;
    n = cyc + 1;
    req = 4'b0100;
    push_ev(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, n);
    push_ev(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, n + 10);
    push_ev(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, n + 11);
    push_ev(1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, n + 15);
    repeat (11) @(negedge clock);
    stall = 1'b0;
    repeat (5) @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    check_idle("timeout_idle");

    // Early drop of req after grant: sequence still completes, no regrant.
    n = cyc + 1;
    req = 4'b0010;
    push_ev(1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, n);
    push_ev(1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010, n + 4);
    @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);
    check_idle("drop_idle");

    // Reset while running: everything clears at once, pointer back to 0.
    n = cyc + 1;
    req = 4'b0100;
    push_ev(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, n);
    repeat (3) @(negedge clock);
    chk("run_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    req = 4'b0000;
    #1;
    chk("reset_run_outputs", {21'd0, go, grant, done, err, busy}, 32'd0);
    @(negedge clock);
    chk("reset_hold_outputs", {21'd0, go, grant, done, err, busy}, 32'd0);
    reset = 1'b1;
    single(4'b1001, 4'b0001);

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
